// File: rtl/seq_detector_pkg.sv
// Shared definitions for the programmable serial pattern detector.
// Used by seq_detector_param and seq_sat_counter.
package seq_detector_pkg;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILLING,
    ST_ARMED
  } fill_state_e;

  function automatic int clamp_len(input int len, input int maxLen);
    return (len > maxLen) ? maxLen : len;
  endfunction

  function automatic int sat_inc(input int value, input int maxVal);
    return (value >= maxVal) ? maxVal : value + 1;
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module seq_sat_counter
  import seq_detector_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// Run-time programmable serial bit-pattern detector with overlap control and match counter.
// Define SEQDET_MASK_EN to add a per-bit don't-care mask (i_cfg_mask) to the compare.
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_load,
  input  logic [PAT_W-1:0] i_cfg_pattern,
  input  logic [LEN_W-1:0] i_cfg_len,
`ifdef SEQDET_MASK_EN
  input  logic [PAT_W-1:0] i_cfg_mask,
`endif
  input  logic             i_cfg_overlap,
  input  logic             i_in_valid,
  input  logic             i_in_bit,
  input  logic             i_cnt_clear,
  output logic             o_match,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic             o_armed
);

  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic             r_match;
  logic             r_armed;
`ifdef SEQDET_MASK_EN
  logic [PAT_W-1:0] r_mask;
`endif

  logic [LEN_W-1:0] w_effLen;
  logic [LEN_W-1:0] w_fillInc;
  logic [LEN_W-1:0] w_fillNext;
  logic [PAT_W-1:0] w_histNext;
  logic [PAT_W-1:0] w_careMask;
  logic             w_hit;
  logic             w_armedNext;
  logic             w_cntInc;
  fill_state_e      w_state;

  // Compare only the low L history bits; the fill count guarantees they are all fresh.
  always_comb begin
    w_effLen   = LEN_W'(clamp_len(int'(r_len), PAT_W));
    w_fillInc  = LEN_W'(sat_inc(int'(r_fill), PAT_W));
    w_histNext = {r_hist[PAT_W-2:0], i_in_bit};
    w_careMask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_careMask[i] = (i < int'(w_effLen));
    end
`ifdef SEQDET_MASK_EN
    w_careMask = w_careMask & ~r_mask;
`endif
    w_hit = i_in_valid && (w_effLen != '0) && (w_fillInc >= w_effLen) &&
            (((w_histNext ^ r_pat) & w_careMask) == '0);
    w_fillNext  = (w_hit && !i_cfg_overlap) ? '0 : w_fillInc;
    w_armedNext = (w_effLen != '0) && (w_fillNext >= w_effLen);
    if (r_fill == '0) begin
      w_state = ST_IDLE;
    end else if ((w_effLen != '0) && (r_fill >= w_effLen)) begin
      w_state = ST_ARMED;
    end else begin
      w_state = ST_FILLING;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pat   <= '0;
      r_len   <= '0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
      r_armed <= 1'b0;
`ifdef SEQDET_MASK_EN
      r_mask  <= '0;
`endif
    end else if (i_cfg_load || i_cnt_clear) begin
      if (i_cfg_load) begin
        r_pat <= i_cfg_pattern;
        r_len <= i_cfg_len;
`ifdef SEQDET_MASK_EN
        r_mask <= i_cfg_mask;
`endif
      end
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
      r_armed <= 1'b0;
    end else if (i_in_valid) begin
      r_hist  <= w_histNext;
      r_fill  <= w_fillNext;
      r_match <= w_hit;
      r_armed <= w_armedNext;
    end else begin
      r_match <= 1'b0;
    end
  end

  // A bit arriving alongside a load or clear is discarded, so its hit must not count.
  assign w_cntInc = w_hit && !i_cfg_load && !i_cnt_clear;

  seq_sat_counter #(
    .CNT_W(CNT_W)
  ) u_matchCnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clear(i_cnt_clear),
    .i_inc  (w_cntInc),
    .o_count(o_match_cnt)
  );

  assign o_match = r_match;
  assign o_armed = r_armed;

  a_fillBound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_fill <= LEN_W'(PAT_W));

  a_armedTracksState: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_armed == (w_state == ST_ARMED));

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus randomized traffic
// against a queue-based reference model. Honours SEQDET_MASK_EN when defined.
module tb_seq_detector_param;

  localparam int PAT_W   = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             cfgLoad;
  logic [PAT_W-1:0] cfgPattern;
  logic [LEN_W-1:0] cfgLen;
  logic [PAT_W-1:0] cfgMask;
  logic             cfgOverlap;
  logic             inValid;
  logic             inBit;
  logic             cntClear;
  logic             match;
  logic [CNT_W-1:0] matchCnt;
  logic             armed;

  int assertCount;
  int failCount;

  logic [PAT_W-1:0] mPat;
  logic [PAT_W-1:0] mMask;
  int               mLen;
  bit               bitsQ[$];
  int               fresh;
  int               mCnt;
  bit               mMatch;
  bit               mArmed;

  seq_detector_param #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W),
    .CNT_W(CNT_W)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfg_load   (cfgLoad),
    .i_cfg_pattern(cfgPattern),
    .i_cfg_len    (cfgLen),
`ifdef SEQDET_MASK_EN
    .i_cfg_mask   (cfgMask),
`endif
    .i_cfg_overlap(cfgOverlap),
    .i_in_valid   (inValid),
    .i_in_bit     (inBit),
    .i_cnt_clear  (cntClear),
    .o_match      (match),
    .o_match_cnt  (matchCnt),
    .o_armed      (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_match"}, 32'(match), 32'(mMatch));
    checkOutput({tag, "_cnt"}, 32'(matchCnt), 32'(mCnt));
    checkOutput({tag, "_armed"}, 32'(armed), 32'(mArmed));
  endtask

  task automatic modelReset();
    mPat  = '0;
    mMask = '0;
    mLen  = 0;
    bitsQ.delete();
    fresh  = 0;
    mCnt   = 0;
    mMatch = 0;
    mArmed = 0;
  endtask

  // Behavioural view: keep recent bits in a queue and count bits since the last restart.
  task automatic modelStep();
    int effL;
    bit hit;
    effL = (mLen > PAT_W) ? PAT_W : mLen;
    if (cfgLoad || cntClear) begin
      if (cfgLoad) begin
        mPat = cfgPattern;
        mLen = int'(cfgLen);
`ifdef SEQDET_MASK_EN
        mMask = cfgMask;
`endif
      end
      if (cntClear) mCnt = 0;
      bitsQ.delete();
      fresh  = 0;
      mMatch = 0;
      mArmed = 0;
    end else if (inValid) begin
      bitsQ.push_back(inBit);
      if (bitsQ.size() > PAT_W) void'(bitsQ.pop_front());
      fresh++;
      hit = (effL > 0) && (fresh >= effL);
      if (hit) begin
        for (int k = 0; k < effL; k++) begin
          if (!mMask[k] && (bitsQ[bitsQ.size() - 1 - k] != mPat[k])) hit = 0;
        end
      end
      mMatch = hit;
      if (hit) begin
        if (mCnt < CNT_MAX) mCnt++;
        if (!cfgOverlap) fresh = 0;
      end
      mArmed = (effL > 0) && (fresh >= effL);
    end else begin
      mMatch = 0;
    end
  endtask

  task automatic applyStimulus(input bit load, input logic [PAT_W-1:0] pat,
                               input logic [LEN_W-1:0] len, input bit ovl,
                               input bit valid, input bit b, input bit clr,
                               input string tag);
    cfgLoad    = load;
    cfgPattern = pat;
    cfgLen     = len;
    cfgOverlap = ovl;
    inValid    = valid;
    inBit      = b;
    cntClear   = clr;
    modelStep();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic loadCfg(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                         input bit ovl);
    applyStimulus(1, pat, len, ovl, 0, 0, 1, "load");
  endtask

  task automatic sendBit(input bit b, input bit ovl, input string tag);
    applyStimulus(0, cfgPattern, cfgLen, ovl, 1, b, 0, tag);
  endtask

  task automatic idleCycle(input bit ovl);
    applyStimulus(0, cfgPattern, cfgLen, ovl, 0, 0, 0, "gap");
  endtask

  initial begin
    logic [6:0] stream7;
    assertCount = 0;
    failCount   = 0;
    cfgMask     = '0;
    cfgLoad     = 0;
    cfgPattern  = '0;
    cfgLen      = '0;
    cfgOverlap  = 0;
    inValid     = 0;
    inBit       = 0;
    cntClear    = 0;
    rst_n       = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    checkAll("reset");

    // Fixed "10" detector equivalence
    loadCfg(8'b0000_0010, 4'd2, 1);
    sendBit(1, 1, "t1b1");
    sendBit(1, 1, "t1b2");
    sendBit(0, 1, "t1b3");
    checkOutput("t1_matchPulse", 32'(match), 32'd1);
    checkOutput("t1_cnt", 32'(matchCnt), 32'd1);
    idleCycle(1);
    checkOutput("t1_matchDrop", 32'(match), 32'd0);

    // Overlapping 1011 over 1011011
    loadCfg(8'b0000_1011, 4'd4, 1);
    stream7 = 7'b1011011;
    for (int i = 0; i < 7; i++) begin
      sendBit(stream7[6-i], 1, "t2");
      if (i == 3 || i == 6) checkOutput("t2_hit", 32'(match), 32'd1);
    end
    checkOutput("t2_cnt", 32'(matchCnt), 32'd2);

    // Non-overlapping variant
    loadCfg(8'b0000_1011, 4'd4, 0);
    for (int i = 0; i < 7; i++) begin
      sendBit(stream7[6-i], 0, "t3");
      if (i == 3) begin
        checkOutput("t3_hit", 32'(match), 32'd1);
        checkOutput("t3_armedAfterHit", 32'(armed), 32'd0);
      end
    end
    checkOutput("t3_noSecond", 32'(match), 32'd0);
    checkOutput("t3_cnt", 32'(matchCnt), 32'd1);
    sendBit(0, 0, "t3b8");
    checkOutput("t3_rearmed", 32'(armed), 32'd1);

    // Counter saturation with a single-bit pattern
    loadCfg(8'b0000_0001, 4'd1, 1);
    for (int i = 0; i < 6; i++) begin
      sendBit(1, 1, "t4");
      checkOutput("t4_pulse", 32'(match), 32'd1);
      checkOutput("t4_sat", 32'(matchCnt), 32'((i + 1 > CNT_MAX) ? CNT_MAX : i + 1));
    end

    // Valid gaps keep the history intact
    loadCfg(8'b0000_1011, 4'd4, 1);
    sendBit(1, 1, "t5");
    sendBit(0, 1, "t5");
    repeat (3) idleCycle(1);
    sendBit(1, 1, "t5");
    checkOutput("t5_early", 32'(match), 32'd0);
    sendBit(1, 1, "t5");
    checkOutput("t5_hit", 32'(match), 32'd1);

    // Asynchronous reset mid-pattern, then load with a coincident bit
    loadCfg(8'b0000_1011, 4'd4, 1);
    sendBit(1, 1, "t6");
    sendBit(0, 1, "t6");
    sendBit(1, 1, "t6");
    #2;
    rst_n = 0;
    #1;
    modelReset();
    checkOutput("t6_rstMatch", 32'(match), 32'd0);
    checkOutput("t6_rstCnt", 32'(matchCnt), 32'd0);
    checkOutput("t6_rstArmed", 32'(armed), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    sendBit(1, 1, "t6post");
    checkOutput("t6_noMatch", 32'(match), 32'd0);
    applyStimulus(1, 8'b0000_1011, 4'd4, 1, 1, 1, 0, "t6loadBit");
    sendBit(0, 1, "t6");
    sendBit(1, 1, "t6");
    sendBit(1, 1, "t6");
    checkOutput("t6_bitDiscarded", 32'(match), 32'd0);
    sendBit(1, 1, "t6");
    sendBit(0, 1, "t6");
    sendBit(1, 1, "t6");
    sendBit(1, 1, "t6");
    checkOutput("t6_freshHit", 32'(match), 32'd1);

    // Randomized traffic, including clamped lengths and coincident load/clear
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
`ifdef SEQDET_MASK_EN
      cfgMask = PAT_W'($urandom) & PAT_W'($urandom);
`endif
      applyStimulus(r < 4, PAT_W'($urandom), LEN_W'($urandom_range(0, 10)),
                    bit'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                    bit'($urandom_range(0, 1)), (r >= 2) && (r < 5), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
